ysyx_25020037_axi_rd_arb: RTL and testbench

Two-master AXI4 read-channel arbiter between the IFU (master 0) and the LSU (master 1) and the single shared read port toward the SoC crossbar.
- One transaction in flight at a time, including bursts.
- Round-robin grant.
- Registered AR forwarding and combinational R routing.
- A watchdog that turns a hung slave into an SLVERR response, so the IFU's access_fault path fires instead of deadlocking.

---
 rtl/ysyx_25020037_axi_rd_arb_pkg.sv | 27 ++
 rtl/ysyx_25020037_rr_pick2.sv | 18 +
 rtl/ysyx_25020037_axi_rd_arb.sv | 169 ++++++++++++++++
 tb/tb_ysyx_25020037_axi_rd_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020037_axi_rd_arb_pkg.sv
// rtl/ysyx_25020037_axi_rd_arb_pkg.sv - shared types and constants for the AXI read arbiter
// Purpose: FSM state encoding, AXI response codes and the latched AR-field bundle.
// Ports: none (package).
package ysyx_25020037_axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Field order of the latched AR bundle: addr, id, len, size, burst.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  localparam int AR_W = 49;

endpackage

// File: rtl/ysyx_25020037_rr_pick2.sv
// rtl/ysyx_25020037_rr_pick2.sv - two-input round-robin chooser
// Purpose: pick one of two requesters, favouring the one not served last.
// Ports: req_i[1:0] requests, last_i last-served index,
//        winner_o chosen index, any_o at least one request.
module ysyx_25020037_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       any_o
);

  always_comb begin
    any_o = |req_i;
    if (&req_i) winner_o = ~last_i;
    else        winner_o = req_i[1];
  end

endmodule

// File: rtl/ysyx_25020037_axi_rd_arb.sv
// rtl/ysyx_25020037_axi_rd_arb.sv - two-master AXI4 read-channel arbiter with watchdog
// Purpose: serialise IFU (m0) and LSU (m1) reads onto one slave read port,
//          registered AR, combinational R, hung-slave watchdog producing SLVERR.
// Ports: clk/rst (sync, active low); m0_*/m1_* master AR/R channels;
//        s_* slave AR/R channels; busy (not idle); grant (current/last master).
module ysyx_25020037_axi_rd_arb
  import ysyx_25020037_axi_rd_arb_pkg::*;
#(
  parameter int TIMEOUT    = 4096,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  input  logic [31:0] m0_araddr,
  input  logic [3:0]  m0_arid,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  input  logic [1:0]  m0_arburst,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  output logic [1:0]  m0_rresp,
  output logic [31:0] m0_rdata,
  output logic        m0_rlast,
  output logic [3:0]  m0_rid,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  input  logic [31:0] m1_araddr,
  input  logic [3:0]  m1_arid,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  input  logic [1:0]  m1_arburst,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [1:0]  m1_rresp,
  output logic [31:0] m1_rdata,
  output logic        m1_rlast,
  output logic [3:0]  m1_rid,
  output logic        s_arvalid,
  input  logic        s_arready,
  output logic [31:0] s_araddr,
  output logic [3:0]  s_arid,
  output logic [7:0]  s_arlen,
  output logic [2:0]  s_arsize,
  output logic [1:0]  s_arburst,
  input  logic        s_rvalid,
  output logic        s_rready,
  input  logic [1:0]  s_rresp,
  input  logic [31:0] s_rdata,
  input  logic        s_rlast,
  input  logic [3:0]  s_rid,
  output logic        busy,
  output logic        grant
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;
  // Firing one count early lets the counter land on TIMEOUT-1 as the state enters ERR.
  localparam logic [WD_W-1:0] WD_FIRE = WD_W'(TIMEOUT - 2);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [AR_W-1:0]   ar_q, ar_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  ar_t               ar_l;
  logic              win, any, g_rready;
  logic              ar_hs, s_ar_hs, beat, err_done, expire;

  ysyx_25020037_rr_pick2 u_pick (
    .req_i   ({m1_arvalid, m0_arvalid}),
    .last_i  (last_q),
    .winner_o(win),
    .any_o   (any)
  );

  assign ar_l     = ar_t'(ar_q);
  assign g_rready = grant_q ? m1_rready : m0_rready;
  assign ar_hs    = (state_q == ST_IDLE) && any;
  assign s_ar_hs  = (state_q == ST_ADDR) && s_arready;
  assign beat     = (state_q == ST_DATA) && s_rvalid && g_rready;
  assign err_done = (state_q == ST_ERR) && g_rready;
  // A beat or AR handshake in the expiry cycle counts as progress, so it wins.
  assign expire   = ((state_q == ST_ADDR) || (state_q == ST_DATA)) &&
                    !s_ar_hs && !beat && (wd_q == WD_FIRE);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any) state_d = ST_ADDR;
      ST_ADDR: begin
        if (s_ar_hs)     state_d = ST_DATA;
        else if (expire) state_d = ST_ERR;
      end
      ST_DATA: begin
        if (beat && s_rlast) state_d = ST_IDLE;
        else if (expire)     state_d = ST_ERR;
      end
      ST_ERR:  if (err_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    ar_d    = ar_q;
    wd_d    = wd_q;
    if (ar_hs) begin
      grant_d = win;
      ar_d    = win ? {m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst}
                    : {m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst};
    end
    if (ar_hs || s_ar_hs || beat)                        wd_d = '0;
    else if ((state_q == ST_ADDR) || (state_q == ST_DATA)) wd_d = wd_q + 1'b1;
    if ((beat && s_rlast) || err_done) last_d = grant_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q <= FIRST_PRIO;
      last_q  <= ~FIRST_PRIO;
      ar_q    <= '0;
      wd_q    <= '0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      ar_q    <= ar_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    m0_arready = ar_hs && !win;
    m1_arready = ar_hs && win;
    s_arvalid  = (state_q == ST_ADDR);
    s_araddr   = ar_l.addr;
    s_arid     = ar_l.id;
    s_arlen    = ar_l.len;
    s_arsize   = ar_l.size;
    s_arburst  = ar_l.burst;
    s_rready   = (state_q == ST_DATA) && g_rready;
    busy       = (state_q != ST_IDLE);
    grant      = grant_q;
    m0_rvalid = 1'b0; m0_rresp = RESP_OKAY; m0_rdata = '0; m0_rlast = 1'b0; m0_rid = '0;
    m1_rvalid = 1'b0; m1_rresp = RESP_OKAY; m1_rdata = '0; m1_rlast = 1'b0; m1_rid = '0;
    if (state_q == ST_DATA) begin
      if (grant_q) begin
        m1_rvalid = s_rvalid; m1_rresp = s_rresp; m1_rdata = s_rdata;
        m1_rlast  = s_rlast;  m1_rid   = s_rid;
      end else begin
        m0_rvalid = s_rvalid; m0_rresp = s_rresp; m0_rdata = s_rdata;
        m0_rlast  = s_rlast;  m0_rid   = s_rid;
      end
    end else if (state_q == ST_ERR) begin
      if (grant_q) begin
        m1_rvalid = 1'b1; m1_rresp = RESP_SLVERR; m1_rlast = 1'b1; m1_rid = ar_l.id;
      end else begin
        m0_rvalid = 1'b1; m0_rresp = RESP_SLVERR; m0_rlast = 1'b1; m0_rid = ar_l.id;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_rd_arb.sv
// tb/tb_ysyx_25020037_axi_rd_arb.sv - self-checking bench for the AXI read arbiter
module tb_ysyx_25020037_axi_rd_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_arvalid = 0, m0_arready, m0_rvalid, m0_rready = 1, m0_rlast;
  logic [31:0] m0_araddr = 0, m0_rdata;
  logic [3:0]  m0_arid = 0, m0_rid;
  logic [7:0]  m0_arlen = 0;
  logic [2:0]  m0_arsize = 3'd2;
  logic [1:0]  m0_arburst = 2'b01, m0_rresp;
  logic        m1_arvalid = 0, m1_arready, m1_rvalid, m1_rready = 1, m1_rlast;
  logic [31:0] m1_araddr = 0, m1_rdata;
  logic [3:0]  m1_arid = 0, m1_rid;
  logic [7:0]  m1_arlen = 0;
  logic [2:0]  m1_arsize = 3'd2;
  logic [1:0]  m1_arburst = 2'b01, m1_rresp;
  logic        s_arvalid, s_arready = 0, s_rvalid = 0, s_rready, s_rlast = 0;
  logic [31:0] s_araddr, s_rdata = 0;
  logic [3:0]  s_arid, s_rid = 0;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp = 0;
  logic        busy, grant;

  int          vec_n = 0;
  int          err_n = 0;
  logic [31:0] rd_base = 0;
  logic        model_last;
  int          exp_w;

  typedef struct {
    logic a0, a1, e0, e1;
  } arb_vec_t;
  arb_vec_t tbl[4];

  ysyx_25020037_axi_rd_arb #(.TIMEOUT(16), .FIRST_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rresp(m0_rresp),
    .m0_rdata(m0_rdata), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rresp(m1_rresp),
    .m1_rdata(m1_rdata), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m0_arready"}, m0_arready, 0);
    chk({tag, "_m1_arready"}, m1_arready, 0);
    chk({tag, "_m0_rvalid"}, m0_rvalid, 0);
    chk({tag, "_m1_rvalid"}, m1_rvalid, 0);
    chk({tag, "_m0_rlast"}, m0_rlast, 0);
    chk({tag, "_m1_rlast"}, m1_rlast, 0);
    chk({tag, "_s_arvalid"}, s_arvalid, 0);
    chk({tag, "_s_rready"}, s_rready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m0_arvalid = 0; m1_arvalid = 0; s_arready = 0; s_rvalid = 0; s_rlast = 0;
    m0_rready = 1; m1_rready = 1;
    tick();
    tick();
    settle();
    chk_reset_outputs("reset");
    rst = 1'b1;
  endtask

  // One full read as seen from the masters and a cooperative slave.
  // gap/stall < 0 select random slave gaps, master stalls, AR delay and rresp.
  task automatic do_txn(input int want, input int gap, input int stall,
                        input int raise_at, input int rst_at);
    int t, w, g, st;
    logic [31:0] a;
    logic [3:0]  id;
    logic [7:0]  ln;
    logic [1:0]  resp;
    t = 0;
    settle();
    while (!m0_arready && !m1_arready && t < 20) begin
      tick(); settle(); t++;
    end
    if (t == 20) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    w  = m1_arready ? 1 : 0;
    chk("winner", w, want);
    chk("loser_arready", w ? m0_arready : m1_arready, 0);
    a  = w ? m1_araddr : m0_araddr;
    id = w ? m1_arid : m0_arid;
    ln = w ? m1_arlen : m0_arlen;
    tick();
    if (w == 1) m1_arvalid = 0; else m0_arvalid = 0;
    settle();
    chk("s_arvalid", s_arvalid, 1);
    chk("s_araddr", s_araddr, a);
    chk("s_arid", s_arid, id);
    chk("s_arlen", s_arlen, ln);
    chk("grant_reg", grant, w);
    if (gap < 0) repeat ($urandom_range(0, 2)) begin tick(); settle(); end
    s_arready = 1;
    tick();
    s_arready = 0;
    for (int b = 0; b <= int'(ln); b++) begin
      if (b == raise_at) begin
        if (w == 1) m0_arvalid = 1; else m1_arvalid = 1;
      end
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) tick();
      resp = (gap < 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      s_rvalid = 1; s_rdata = rd_base + 32'(b); s_rlast = (b == int'(ln));
      s_rid = id; s_rresp = resp;
      if (b == rst_at) begin
        rst = 0;
        tick();
        s_rvalid = 0; s_rlast = 0;
        settle();
        chk_reset_outputs("midrst");
        rst = 1;
        return;
      end
      st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      if (w == 1) m1_rready = 0; else m0_rready = 0;
      for (int k = 0; k < st; k++) begin
        settle();
        chk("bp_s_rready", s_rready, 0);
        chk("bp_rvalid", w ? m1_rvalid : m0_rvalid, 1);
        chk("bp_rresp", w ? m1_rresp : m0_rresp, resp);
        tick();
      end
      m0_rready = 1; m1_rready = 1;
      settle();
      chk("beat_rvalid", w ? m1_rvalid : m0_rvalid, 1);
      chk("beat_rdata", w ? m1_rdata : m0_rdata, rd_base + 32'(b));
      chk("beat_rlast", w ? m1_rlast : m0_rlast, (b == int'(ln)));
      chk("beat_rresp", w ? m1_rresp : m0_rresp, resp);
      chk("beat_rid", w ? m1_rid : m0_rid, id);
      chk("other_rvalid", w ? m0_rvalid : m1_rvalid, 0);
      chk("other_arready", w ? m0_arready : m1_arready, 0);
      chk("beat_s_rready", s_rready, 1);
      tick();
      s_rvalid = 0; s_rlast = 0;
      settle();
      chk("busy_after_beat", busy, (b != int'(ln)));
      chk("no_repeat_beat", w ? m1_rvalid : m0_rvalid, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{a0: 0, a1: 0, e0: 0, e1: 0};
    tbl[1] = '{a0: 1, a1: 0, e0: 1, e1: 0};
    tbl[2] = '{a0: 0, a1: 1, e0: 0, e1: 1};
    tbl[3] = '{a0: 1, a1: 1, e0: 1, e1: 0};

    do_reset();

    // IDLE arbitration after reset, applied and withdrawn within one cycle.
    for (int i = 0; i < 4; i++) begin
      m0_arvalid = tbl[i].a0; m1_arvalid = tbl[i].a1;
      settle();
      chk("tbl_m0_arready", m0_arready, tbl[i].e0);
      chk("tbl_m1_arready", m1_arready, tbl[i].e1);
    end
    m0_arvalid = 0; m1_arvalid = 0;

    // Single IFU read.
    tick();
    m0_araddr = 32'h3000_0000; m0_arid = 4'h3; m0_arlen = 0; m0_arvalid = 1;
    rd_base = 32'hDEAD_BEEF;
    do_txn(0, 0, 0, -1, -1);

    // Contention after reset, then alternation.
    do_reset();
    m0_araddr = 32'h3000_0010; m0_arid = 4'h1; m0_arlen = 0; m0_arvalid = 1;
    m1_araddr = 32'h8000_0020; m1_arid = 4'h2; m1_arlen = 1; m1_arvalid = 1;
    rd_base = 32'h1111_0000;
    do_txn(0, 0, 0, -1, -1);
    rd_base = 32'h2222_0000;
    do_txn(1, 0, 0, -1, -1);
    m0_arvalid = 1; m1_arvalid = 1;
    do_txn(0, 0, 0, -1, -1);
    do_txn(1, 0, 0, -1, -1);

    // SDRAM burst with slave gaps; m0 raised mid-burst waits and goes next.
    m1_araddr = 32'hA000_0000; m1_arid = 4'h7; m1_arlen = 3; m1_arburst = 2'b01;
    m1_arvalid = 1;
    m0_araddr = 32'h3000_0100; m0_arid = 4'h4; m0_arlen = 0;
    rd_base = 32'h5000_0000;
    do_txn(1, 1, 0, 2, -1);
    rd_base = 32'h6000_0000;
    do_txn(0, 0, 0, -1, -1);

    // Back-pressure: m0 holds rready low for 5 cycles on a visible beat.
    m0_arvalid = 1; m0_araddr = 32'h3000_0200; m0_arid = 4'h6;
    rd_base = 32'h7777_0000;
    do_txn(0, 0, 5, -1, -1);

    // Hung slave: AR accepted, no R ever; watchdog fires after 15 DATA cycles.
    m0_arvalid = 1; m0_araddr = 32'h3000_0300; m0_arid = 4'h5; m0_arlen = 0;
    settle();
    chk("hung_arready", m0_arready, 1);
    tick();
    m0_arvalid = 0; s_arready = 1;
    tick();
    s_arready = 0;
    for (int i = 0; i < 15; i++) begin
      settle();
      chk("hung_quiet", m0_rvalid, 0);
      tick();
    end
    s_rvalid = 1; s_rdata = 32'h1234_5678; s_rlast = 1; s_rid = 4'h5;
    settle();
    chk("err_rvalid", m0_rvalid, 1);
    chk("err_rresp", m0_rresp, 2'b10);
    chk("err_rlast", m0_rlast, 1);
    chk("err_rdata", m0_rdata, 0);
    chk("err_rid", m0_rid, 4'h5);
    chk("err_s_rready", s_rready, 0);
    chk("err_m1_rvalid", m1_rvalid, 0);
    chk("err_busy", busy, 1);
    tick();
    s_rvalid = 0; s_rlast = 0;
    settle();
    chk("err_idle", busy, 0);
    m1_arvalid = 1; m1_araddr = 32'h8000_0400; m1_arid = 4'h9; m1_arlen = 1;
    rd_base = 32'h9999_0000;
    do_txn(1, 0, 0, -1, -1);

    // Reset during beat 2 of 4, then a fresh m0 read.
    m1_arvalid = 1; m1_araddr = 32'hA000_0040; m1_arid = 4'hA; m1_arlen = 3;
    rd_base = 32'hAAAA_0000;
    do_txn(1, 0, 0, -1, 2);
    m0_arvalid = 1; m0_araddr = 32'h3000_0500; m0_arid = 4'hB; m0_arlen = 1;
    rd_base = 32'hBBBB_0000;
    do_txn(0, 0, 0, -1, -1);

    // Randomized traffic against a request-level round-robin model.
    do_reset();
    model_last = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (!m0_arvalid && $urandom_range(0, 1) == 1) begin
        m0_arvalid = 1; m0_araddr = $urandom; m0_arid = 4'($urandom);
        m0_arlen = 8'($urandom_range(0, 3));
      end
      if (!m1_arvalid && $urandom_range(0, 1) == 1) begin
        m1_arvalid = 1; m1_araddr = $urandom; m1_arid = 4'($urandom);
        m1_arlen = 8'($urandom_range(0, 3));
      end
      if (!m0_arvalid && !m1_arvalid) begin
        m0_arvalid = 1; m0_araddr = $urandom; m0_arid = 4'($urandom);
        m0_arlen = 8'($urandom_range(0, 3));
      end
      if (m0_arvalid && m1_arvalid) exp_w = model_last ? 0 : 1;
      else                          exp_w = m1_arvalid ? 1 : 0;
      rd_base = $urandom;
      do_txn(exp_w, -1, -1, -1, -1);
      model_last = (exp_w == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
